// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller:
// FSM states, ALU operation codes, data-processing commands and condition codes.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_UNKNOWN = 4'd10
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // Funct[4:1] command field of data-processing instructions
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/mc_controller_cond_logic.sv
// Flags register plus condition-code evaluation. {N,Z} and {C,V} load
// independently so logical ops can leave carry/overflow untouched.
module cond_logic
    import mc_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic [1:0] flag_write_i,
    output logic       cond_ex_o
);

    logic [1:0] nz_q;
    logic [1:0] cv_q;
    logic       n, z, c, v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            if (flag_write_i[1]) nz_q <= alu_flags_i[3:2];
            if (flag_write_i[0]) cv_q <= alu_flags_i[1:0];
        end
    end

    assign {n, z} = nz_q;
    assign {c, v} = cv_q;

    always_comb begin
        cond_ex_o = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: main FSM, instruction decoders and
// conditional-execution gating of register, memory and PC writes.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  State
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] cmd;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instr[7:4];

    state_t     state_q, state_d;
    logic       cond_ex_q;
    logic       cond_ex;
    logic [1:0] flag_write;
    logic       cmd_ok, no_write, cv_op, wb_pc;
    logic [1:0] alu_op;

    cond_logic u_cond_logic (
        .clk          (clk),
        .reset        (reset),
        .cond_i       (cond),
        .alu_flags_i  (ALUFlags),
        .flag_write_i (flag_write),
        .cond_ex_o    (cond_ex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cond_ex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cond_ex_q <= cond_ex;
        end
    end

    always_comb begin
        cmd_ok   = 1'b1;
        no_write = 1'b0;
        alu_op   = ALU_ADD;
        case (cmd)
            CMD_ADD: alu_op = ALU_ADD;
            CMD_SUB: alu_op = ALU_SUB;
            CMD_AND: alu_op = ALU_AND;
            CMD_ORR: alu_op = ALU_ORR;
            CMD_CMP: begin
                alu_op   = ALU_SUB;
                no_write = 1'b1;
            end
            default: cmd_ok = 1'b0;
        endcase
    end

    // Carry/overflow are only meaningful for the arithmetic commands
    assign cv_op = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
    assign wb_pc = (rd == 4'd15);

    assign RegSrc = {op == 2'b01, op == 2'b10};
    assign ImmSrc = op;
    assign State  = state_q;

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        flag_write = 2'b00;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (op == 2'b01)                state_d = S_MEMADR;
                else if (op == 2'b00 && cmd_ok) state_d = funct[5] ? S_EXECI : S_EXECR;
                else if (op == 2'b10)           state_d = S_BRANCH;
                else                            state_d = S_UNKNOWN;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex_q & ~wb_pc;
                PCWrite   = cond_ex_q & wb_pc;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_q;
                state_d  = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_op;
                flag_write = {2{funct[0] & cond_ex_q}} & {1'b1, cv_op};
                state_d    = no_write ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = cond_ex_q & ~wb_pc;
                PCWrite  = cond_ex_q & wb_pc;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks instruction sequences cycle by cycle
// and compares State and control outputs against hand-derived values.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] instr = 20'h0;
    logic [3:0]  alu_flags = 4'h0;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  State;
    logic [4:0]  en;

    int vectors = 0;
    int miscompares = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (instr),
        .ALUFlags   (alu_flags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .State      (State)
    );

    always #5 clk = ~clk;

    assign en = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        instr = 20'hE5903;
        #2;
        vectors++;
        if (State !== S_FETCH || en !== 5'b10010) begin
            miscompares++;
            $display("FAIL reset_fetch state=%0d en=%b expected state=%0d en=10010", State, en, S_FETCH);
        end
        vectors++;
        if ({ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== 8'b01_10_10_00) begin
            miscompares++;
            $display("FAIL reset_muxes got %b expected 01101000", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl});
        end
        vectors++;
        if (RegSrc !== 2'b10 || ImmSrc !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_ldr_decode RegSrc=%b ImmSrc=%b expected 10 01", RegSrc, ImmSrc);
        end
        instr = 20'h0A000;
        #1;
        vectors++;
        if (RegSrc !== 2'b01 || ImmSrc !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_b_decode RegSrc=%b ImmSrc=%b expected 01 10", RegSrc, ImmSrc);
        end
        tick();
        vectors++;
        if (State !== S_FETCH) begin
            miscompares++;
            $display("FAIL reset_held state=%0d expected %0d", State, S_FETCH);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (State !== S_FETCH || en !== 5'b10010) begin
            miscompares++;
            $display("FAIL reset_release state=%0d en=%b expected state=0 en=10010", State, en);
        end
    endtask

    // ADD R1,R2,#5 (S=0, ALUFlags show Z) then BEQ: flags must not have loaded
    task automatic test_add_imm();
        logic [3:0] es [8];
        logic [4:0] ee [8];
        es = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b00100, 5'b10010, 5'b00000, 5'b00000, 5'b10010};
        instr = 20'hE2821;
        alu_flags = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            if (i == 4) instr = 20'h0A000;
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL add_imm[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
            if (es[i] == S_EXECI) begin
                vectors++;
                if (ALUControl !== 2'b00 || ALUSrcA !== 2'b00 || ALUSrcB !== 2'b01) begin
                    miscompares++;
                    $display("FAIL add_imm_execi ALUControl=%b ALUSrcA=%b ALUSrcB=%b expected 00 00 01", ALUControl, ALUSrcA, ALUSrcB);
                end
            end
        end
    endtask

    task automatic test_ldr();
        logic [3:0] es [6];
        logic [4:0] ee [6];
        es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b00001, 5'b00100, 5'b10010};
        instr = 20'hE5903;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL ldr[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
            if (es[i] == S_MEMWB) begin
                vectors++;
                if (ResultSrc !== 2'b01) begin
                    miscompares++;
                    $display("FAIL ldr_memwb ResultSrc=%b expected 01", ResultSrc);
                end
            end
        end
    endtask

    // SUBS R0,R0,R0 then BEQ, first with Z=1 (taken) then Z=0 (not taken)
    task automatic test_branch();
        logic [3:0] es [8];
        logic [4:0] ee [8];
        es = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        for (int c = 0; c < 2; c++) begin
            ee = '{5'b10010, 5'b00000, 5'b00000, 5'b00100, 5'b10010, 5'b00000,
                   (c == 0) ? 5'b10000 : 5'b00000, 5'b10010};
            instr = 20'hE0500;
            alu_flags = (c == 0) ? 4'b0100 : 4'b0000;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) tick();
                if (i == 4) instr = 20'h0A000;
                vectors++;
                if (State !== es[i] || en !== ee[i]) begin
                    miscompares++;
                    $display("FAIL branch%0d[%0d] state=%0d en=%b expected state=%0d en=%b", c, i, State, en, es[i], ee[i]);
                end
                if (es[i] == S_EXECR) begin
                    vectors++;
                    if (ALUControl !== 2'b01) begin
                        miscompares++;
                        $display("FAIL subs_alucontrol got %b expected 01", ALUControl);
                    end
                end
            end
        end
    endtask

    // Flags Z=0: ADDEQ must not write back, BNE must be taken
    task automatic test_cond_fail();
        logic [3:0] es [8];
        logic [4:0] ee [8];
        es = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b00000, 5'b10010, 5'b00000, 5'b10000, 5'b10010};
        instr = 20'h02821;
        alu_flags = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            if (i == 4) instr = 20'h1A000;
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL cond_fail[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
        end
    endtask

    // CMP with N=1,V=0 skips ALUWB; BLT taken, BGE not taken
    task automatic test_cmp();
        logic [3:0] es [10];
        logic [4:0] ee [10];
        es = '{S_FETCH, S_DECODE, S_EXECR, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b10010, 5'b00000, 5'b10000, 5'b10010, 5'b00000, 5'b00000, 5'b10010};
        instr = 20'hE1500;
        alu_flags = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            if (i == 3) instr = 20'hBA000;
            if (i == 6) instr = 20'hAA000;
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL cmp[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
            if (es[i] == S_EXECR) begin
                vectors++;
                if (ALUControl !== 2'b01 || ALUSrcB !== 2'b00) begin
                    miscompares++;
                    $display("FAIL cmp_execr ALUControl=%b ALUSrcB=%b expected 01 00", ALUControl, ALUSrcB);
                end
            end
        end
    endtask

    // ORRS with C=1,V=1 on the ALU: N,Z load but C stays 0 -> BCS not taken, BPL taken
    task automatic test_orrs_cv();
        logic [3:0] es [11];
        logic [4:0] ee [11];
        es = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_DECODE, S_BRANCH, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b00100, 5'b10010, 5'b00000, 5'b00000, 5'b10010, 5'b00000, 5'b10000, 5'b10010};
        instr = 20'hE1911;
        alu_flags = 4'b0011;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) tick();
            if (i == 4) instr = 20'h2A000;
            if (i == 7) instr = 20'h5A000;
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL orrs[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
            if (es[i] == S_EXECR) begin
                vectors++;
                if (ALUControl !== 2'b11) begin
                    miscompares++;
                    $display("FAIL orrs_alucontrol got %b expected 11", ALUControl);
                end
            end
        end
    endtask

    task automatic test_rd15();
        logic [3:0] es [5];
        logic [4:0] ee [5];
        es = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b10000, 5'b10010};
        instr = 20'hE081F;
        alu_flags = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL rd15[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
            if (es[i] == S_ALUWB) begin
                vectors++;
                if (ResultSrc !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rd15_aluwb ResultSrc=%b expected 00", ResultSrc);
                end
            end
        end
    endtask

    // Op=11, then an unsupported data-processing command (EOR)
    task automatic test_unknown();
        logic [3:0] es [7];
        logic [4:0] ee [7];
        es = '{S_FETCH, S_DECODE, S_UNKNOWN, S_FETCH, S_DECODE, S_UNKNOWN, S_FETCH};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b10010, 5'b00000, 5'b00000, 5'b10010};
        instr = 20'hEC000;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (i == 3) instr = 20'hE0211;
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL unknown[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
            if (es[i] == S_UNKNOWN) begin
                vectors++;
                if ({ALUSrcA, ALUSrcB, ResultSrc, ALUControl} !== 8'h00) begin
                    miscompares++;
                    $display("FAIL unknown_muxes got %b expected 00000000", {ALUSrcA, ALUSrcB, ResultSrc, ALUControl});
                end
            end
        end
    endtask

    // STR reaches MEMWR, then reset is raised between clock edges
    task automatic test_mid_reset();
        logic [3:0] es [4];
        logic [4:0] ee [4];
        es = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
        ee = '{5'b10010, 5'b00000, 5'b00000, 5'b01001};
        instr = 20'hE5803;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            vectors++;
            if (State !== es[i] || en !== ee[i]) begin
                miscompares++;
                $display("FAIL str[%0d] state=%0d en=%b expected state=%0d en=%b", i, State, en, es[i], ee[i]);
            end
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (MemWrite !== 1'b0 || State !== S_FETCH) begin
            miscompares++;
            $display("FAIL async_reset MemWrite=%b state=%0d expected 0 and %0d", MemWrite, State, S_FETCH);
        end
        tick();
        reset = 1'b0;
        instr = 20'h0A000;
        #1;
        vectors++;
        if (State !== S_FETCH || en !== 5'b10010) begin
            miscompares++;
            $display("FAIL post_reset state=%0d en=%b expected state=0 en=10010", State, en);
        end
        tick();
        vectors++;
        if (State !== S_DECODE) begin
            miscompares++;
            $display("FAIL post_reset_decode state=%0d expected %0d", State, S_DECODE);
        end
        tick();
        tick();
        vectors++;
        if (State !== S_FETCH) begin
            miscompares++;
            $display("FAIL post_reset_return state=%0d expected %0d", State, S_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_ldr();
        test_branch();
        test_cond_fail();
        test_cmp();
        test_orrs_cv();
        test_rd15();
        test_unknown();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
